// File: rtl/apb_pkg.sv
// Shared definitions for the multi-slave APB master: FSM encoding,
// response status bundle and the default ACCESS timeout.
package apb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam int DEFAULT_TIMEOUT = 16;

  typedef struct packed {
    logic err;
    logic timeout;
  } rsp_status_t;

endpackage

// File: rtl/apb_slave_mux.sv
// Picks the PREADY/PSLVERR/PRDATA of the slave addressed by the captured
// index; every other slave's response lines are ignored.
module apb_slave_mux #(
  parameter int NUM_SLV = 4,
  parameter int DATA_W  = 21,
  parameter int IDX_W   = 2
) (
  input  logic [IDX_W-1:0]          sel_idx,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  output logic                      sel_ready,
  output logic                      sel_err,
  output logic [DATA_W-1:0]         sel_rdata
);

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/apb_master_mc.sv
// Multi-slave APB3 master: takes one CPU request at a time, runs a SETUP/ACCESS
// transfer to the decoded slave and returns data, slave error and timeout status.
module apb_master_mc
  import apb_pkg::*;
#(
  parameter int  ADDR_W  = 8,
  parameter int  DATA_W  = 21,
  parameter int  NUM_SLV = 4,
  parameter int  TIMEOUT = DEFAULT_TIMEOUT,
  localparam int IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [IDX_W-1:0]          req_idx,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [IDX_W:0] SLV_LIMIT = (IDX_W + 1)'(NUM_SLV);

  logic [1:0]         state;
  logic [IDX_W-1:0]   sel_idx;
  logic [CNT_W-1:0]   wait_cnt;
  rsp_status_t        rsp_stat;
  logic [NUM_SLV-1:0] psel_dec;
  logic               decode_err;
  logic               timeout_hit;
  logic               sel_ready;
  logic               sel_err;
  logic [DATA_W-1:0]  sel_rdata;

  apb_slave_mux #(
    .NUM_SLV (NUM_SLV),
    .DATA_W  (DATA_W),
    .IDX_W   (IDX_W)
  ) u_mux (
    .sel_idx   (sel_idx),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .PRDATA    (PRDATA),
    .sel_ready (sel_ready),
    .sel_err   (sel_err),
    .sel_rdata (sel_rdata)
  );

  always_comb begin
    psel_dec = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      psel_dec[i] = (req_idx == IDX_W'(i));
    end
  end

  assign decode_err  = ({1'b0, req_idx} >= SLV_LIMIT);
  // The abort fires on the edge that would make the waited-cycle count reach TIMEOUT.
  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == CNT_W'(TO_LAST));
  assign rsp_err     = rsp_stat.err;
  assign rsp_timeout = rsp_stat.timeout;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      sel_idx   <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_stat  <= '0;
      rsp_rdata <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_stat  <= '0;
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            if (decode_err) begin
              rsp_valid    <= 1'b1;
              rsp_stat.err <= 1'b1;
              rsp_rdata    <= '0;
            end else begin
              PWRITE    <= req_write;
              PADDR     <= req_addr;
              PWDATA    <= req_wdata;
              PSEL      <= psel_dec;
              sel_idx   <= req_idx;
              req_ready <= 1'b0;
              state     <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // PREADY is checked first so a ready slave beats a simultaneous timeout.
          if (sel_ready || timeout_hit) begin
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
            if (sel_ready) begin
              rsp_stat.err <= sel_err;
              rsp_rdata    <= (!PWRITE && !sel_err) ? sel_rdata : '0;
            end else begin
              rsp_stat.err     <= 1'b1;
              rsp_stat.timeout <= 1'b1;
              rsp_rdata        <= '0;
            end
          end else if (wait_cnt != {CNT_W{1'b1}}) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
